// File: rtl/sort_pkg.sv
// Shared constants, FSM state type and width clamp for the sort job arbiter.
package sort_pkg;

  localparam int N_ELEM  = 30;
  localparam int ELEM_W  = 7;
  localparam int WIDTH_W = 5;
  localparam int ARR_W   = N_ELEM * ELEM_W;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    LAUNCH  = 5'b00010,
    RUN     = 5'b00100,
    DELIVER = 5'b01000,
    RELEASE = 5'b10000
  } state_t;

  // The engine cannot sort more elements than it holds, so larger requests are cut to N_ELEM.
  function automatic logic [WIDTH_W-1:0] clampWidth(input logic [WIDTH_W-1:0] w);
    return (w > WIDTH_W'(N_ELEM)) ? WIDTH_W'(N_ELEM) : w;
  endfunction

endpackage

// File: rtl/sort_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module sort_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [IDX_W:0] w_pos;

  // Walk the requests starting at rr_ptr and keep only the first one found.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(N_REQ);
      end
      if (!any && req[w_pos[IDX_W-1:0]]) begin
        any                      = 1'b1;
        grant[w_pos[IDX_W-1:0]]  = 1'b1;
        index                    = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sort_job_arbiter.sv
// Shares one bubble-sort engine between N_REQ clients, granting jobs round-robin.
// Optional statistics counters (jobs_done, busy_cycles) are built when SORT_STATS_EN is defined.
module sort_job_arbiter
  import sort_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH_W-1:0]   req_width,
  input  logic [N_REQ*ARR_W-1:0]     req_data,
  output logic [N_REQ-1:0]           req_accept,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ack,
  output logic [ARR_W-1:0]           rsp_data,
  output logic                       busy,
  output logic                       eng_Start,
  output logic [WIDTH_W-1:0]         eng_width,
  output logic [ARR_W-1:0]           eng_Ain,
  output logic                       eng_Ack,
  input  logic                       eng_Done,
  input  logic [ARR_W-1:0]           eng_Aout
`ifdef SORT_STATS_EN
  ,
  output logic [15:0]                jobs_done,
  output logic [31:0]                busy_cycles
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rrPtr;
  logic [IDX_W-1:0]   r_grantIdx;
  logic [N_REQ-1:0]   r_grantOh;
  logic [N_REQ-1:0]   r_reqAccept;
  logic [N_REQ-1:0]   r_rspValid;
  logic               r_engStart;
  logic               r_engAck;
  logic [ARR_W-1:0]   r_ain;
  logic [WIDTH_W-1:0] r_width;

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_index;
  logic               w_any;
  logic [IDX_W-1:0]   w_nextPtr;
  logic [WIDTH_W-1:0] w_reqWidth;
  logic               w_ownerAck;

  sort_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (r_rrPtr),
    .grant  (w_grant),
    .index  (w_index),
    .any    (w_any)
  );

  assign w_reqWidth = req_width[w_index*WIDTH_W +: WIDTH_W];
  assign w_ownerAck = |(rsp_ack & r_grantOh);
  assign w_nextPtr  = (r_grantIdx == IDX_W'(N_REQ-1)) ? '0 : r_grantIdx + 1'b1;

  assign req_accept = r_reqAccept;
  assign rsp_valid  = r_rspValid;
  assign rsp_data   = eng_Aout;
  assign busy       = (r_state != IDLE);
  assign eng_Start  = r_engStart;
  assign eng_width  = r_width;
  assign eng_Ain    = r_ain;
  assign eng_Ack    = r_engAck;

  // Job lifecycle: grab a job, start the engine, hand back the result, release the engine.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_rrPtr     <= '0;
      r_grantIdx  <= '0;
      r_grantOh   <= '0;
      r_reqAccept <= '0;
      r_rspValid  <= '0;
      r_engStart  <= 1'b0;
      r_engAck    <= 1'b0;
      r_ain       <= '0;
      r_width     <= '0;
    end else begin
      r_reqAccept <= '0;
      r_engStart  <= 1'b0;
      r_engAck    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_reqAccept <= w_grant;
            r_grantOh   <= w_grant;
            r_grantIdx  <= w_index;
            r_ain       <= req_data[w_index*ARR_W +: ARR_W];
            r_width     <= clampWidth(w_reqWidth);
            r_engStart  <= 1'b1;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_state <= RUN;
        end
        RUN: begin
          if (eng_Done) begin
            r_rspValid <= r_grantOh;
            r_state    <= DELIVER;
          end
        end
        DELIVER: begin
          if (w_ownerAck) begin
            r_rspValid <= '0;
            r_engAck   <= 1'b1;
            r_state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (!eng_Done) begin
            r_rrPtr <= w_nextPtr;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SORT_STATS_EN
  logic [15:0] r_jobsDone;
  logic [31:0] r_busyCycles;

  assign jobs_done   = r_jobsDone;
  assign busy_cycles = r_busyCycles;

  // Count finished jobs (wrapping) and busy cycles (saturating).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_jobsDone   <= '0;
      r_busyCycles <= '0;
    end else begin
      if (r_state == RELEASE && !eng_Done) begin
        r_jobsDone <= r_jobsDone + 16'd1;
      end
      if (busy && (r_busyCycles != '1)) begin
        r_busyCycles <= r_busyCycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Self-checking bench for sort_job_arbiter: behavioural engine, random clients and a
// job-level reference model compared against the DUT on every cycle.
module tb_sort_job_arbiter;
  import sort_pkg::*;

  localparam int N_REQ = 4;
  localparam int PH_FREE = 0, PH_START = 1, PH_SORT = 2, PH_RESP = 3, PH_REL = 4;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*WIDTH_W-1:0] req_width;
  logic [N_REQ*ARR_W-1:0]   req_data;
  logic [N_REQ-1:0]         req_accept;
  logic [N_REQ-1:0]         rsp_valid;
  logic [N_REQ-1:0]         rsp_ack;
  logic [ARR_W-1:0]         rsp_data;
  logic                     busy;
  logic                     eng_Start;
  logic [WIDTH_W-1:0]       eng_width;
  logic [ARR_W-1:0]         eng_Ain;
  logic                     eng_Ack;
  logic                     eng_Done;
  logic [ARR_W-1:0]         eng_Aout;
`ifdef SORT_STATS_EN
  logic [15:0]              jobs_done;
  logic [31:0]              busy_cycles;
`endif

  sort_job_arbiter #(.N_REQ(N_REQ)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_width  (req_width),
    .req_data   (req_data),
    .req_accept (req_accept),
    .rsp_valid  (rsp_valid),
    .rsp_ack    (rsp_ack),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .eng_Start  (eng_Start),
    .eng_width  (eng_width),
    .eng_Ain    (eng_Ain),
    .eng_Ack    (eng_Ack),
    .eng_Done   (eng_Done),
    .eng_Aout   (eng_Aout)
`ifdef SORT_STATS_EN
    ,
    .jobs_done   (jobs_done),
    .busy_cycles (busy_cycles)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int               phase, mPtr, mOwner, mJobs;
  longint           mBusyCycles;
  logic [ARR_W-1:0] mAin, mSorted;
  logic [WIDTH_W-1:0] mWidth;
  logic [N_REQ-1:0] expAccept, expRspValid;
  logic             expStart, expBusy, expAck;

  // Stimulus knobs and pending client jobs
  bit               holdAll, autoReq, ackBlock;
  int               engLatMin, engLatMax;
  bit               injPend [N_REQ];
  int               injW    [N_REQ];
  logic [ARR_W-1:0] injD    [N_REQ];

  // Behavioural engine
  bit               engRunning;
  int               engCount, engW, engDropCount;
  logic [ARR_W-1:0] engAin;

  int               grantLog[$];
  int               ackPulses;

  // Counting sort of the first w elements; the rest stay put.
  function automatic logic [ARR_W-1:0] refSort(input logic [ARR_W-1:0] a, input int w);
    int hist[128];
    int pos;
    logic [ARR_W-1:0] r;
    r = a;
    for (int v = 0; v < 128; v++) hist[v] = 0;
    for (int i = 0; i < w; i++) hist[int'(a[i*ELEM_W +: ELEM_W])]++;
    pos = 0;
    for (int v = 0; v < 128; v++) begin
      for (int c = 0; c < hist[v]; c++) begin
        r[pos*ELEM_W +: ELEM_W] = ELEM_W'(v);
        pos++;
      end
    end
    return r;
  endfunction

  function automatic int rrPick(input logic [N_REQ-1:0] rv, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (rv[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [ARR_W-1:0] randArr();
    logic [ARR_W-1:0] r;
    for (int i = 0; i < N_ELEM; i++) r[i*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
    return r;
  endfunction

  function automatic bit anyInj();
    for (int i = 0; i < N_REQ; i++) if (injPend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWide(input string name, input logic [ARR_W-1:0] act, input logic [ARR_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic queueJob(input int i, input int w, input logic [ARR_W-1:0] d);
    injPend[i] = 1'b1;
    injW[i]    = w;
    injD[i]    = d;
  endtask

  task automatic newJob(input int i, input int w, input logic [ARR_W-1:0] d);
    req_width[i*WIDTH_W +: WIDTH_W] = WIDTH_W'(w);
    req_data[i*ARR_W +: ARR_W]      = d;
    req_valid[i]                    = 1'b1;
  endtask

  // Compare every DUT output against what the model predicted for this cycle.
  task automatic checkOutput();
    check("req_accept", 64'(req_accept), 64'(expAccept));
    check("eng_Start", 64'(eng_Start), 64'(expStart));
    check("busy", 64'(busy), 64'(expBusy));
    check("rsp_valid", 64'(rsp_valid), 64'(expRspValid));
    check("eng_Ack", 64'(eng_Ack), 64'(expAck));
    if (expRspValid != '0) checkWide("rsp_data", rsp_data, mSorted);
    if (expStart) begin
      checkWide("eng_Ain", eng_Ain, mAin);
      check("eng_width", 64'(eng_width), 64'(mWidth));
    end
`ifdef SORT_STATS_EN
    check("jobs_done", 64'(jobs_done), 64'(mJobs[15:0]));
    check("busy_cycles", 64'(busy_cycles), 64'(mBusyCycles));
`endif
  endtask

  // Drive clients and engine for the next edge, then predict the outputs after it.
  task automatic applyStimulus();
    logic [N_REQ-1:0] obsAccept;
    logic             obsStart, obsAck;
    int               g;
    obsAccept = req_accept;
    obsStart  = eng_Start;
    obsAck    = eng_Ack;
    for (int i = 0; i < N_REQ; i++) if (obsAccept[i]) grantLog.push_back(i);
    if (obsAck) ackPulses++;

    for (int i = 0; i < N_REQ; i++) begin
      if (obsAccept[i]) begin
        if (holdAll) newJob(i, $urandom_range(31, 0), randArr());
        else req_valid[i] = 1'b0;
      end
      if (injPend[i]) begin
        newJob(i, injW[i], injD[i]);
        injPend[i] = 1'b0;
      end else if (autoReq && !req_valid[i] && ($urandom % 6 == 0)) begin
        newJob(i, $urandom_range(31, 0), randArr());
      end
    end
    rsp_ack = ackBlock ? '0 : N_REQ'($urandom);

    if (obsStart) begin
      engRunning = 1'b1;
      engAin     = eng_Ain;
      engW       = int'(eng_width);
      engCount   = (engW < 2) ? 1 : $urandom_range(engLatMax, engLatMin);
    end else if (engRunning) begin
      engCount--;
      if (engCount == 0) begin
        engRunning = 1'b0;
        eng_Done   = 1'b1;
        eng_Aout   = refSort(engAin, engW);
      end
    end
    if (obsAck) begin
      engDropCount = 1 + ($urandom % 3);
    end else if (engDropCount > 0) begin
      engDropCount--;
      if (engDropCount == 0) eng_Done = 1'b0;
    end

    if (phase != PH_FREE) mBusyCycles++;
    expAccept = '0;
    expStart  = 1'b0;
    expAck    = 1'b0;
    case (phase)
      PH_FREE: begin
        g = rrPick(req_valid, mPtr);
        if (g >= 0) begin
          expAccept[g] = 1'b1;
          expStart     = 1'b1;
          mOwner       = g;
          mAin         = req_data[g*ARR_W +: ARR_W];
          mWidth       = WIDTH_W'((int'(req_width[g*WIDTH_W +: WIDTH_W]) > N_ELEM) ? N_ELEM : int'(req_width[g*WIDTH_W +: WIDTH_W]));
          mSorted      = refSort(mAin, int'(mWidth));
          phase        = PH_START;
        end
      end
      PH_START: phase = PH_SORT;
      PH_SORT: begin
        if (eng_Done) begin
          expRspValid         = '0;
          expRspValid[mOwner] = 1'b1;
          phase               = PH_RESP;
        end
      end
      PH_RESP: begin
        if (rsp_ack[mOwner]) begin
          expRspValid = '0;
          expAck      = 1'b1;
          phase       = PH_REL;
        end
      end
      default: begin
        if (!eng_Done) begin
          phase = PH_FREE;
          mPtr  = (mOwner + 1) % N_REQ;
          mJobs++;
        end
      end
    endcase
    expBusy = (phase != PH_FREE);
  endtask

  task automatic stepCycle();
    @(negedge Clk);
    checkOutput();
    applyStimulus();
  endtask

  // Pulse Reset mid-cycle and confirm the outputs drop immediately.
  task automatic applyReset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("reset req_accept", 64'(req_accept), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset eng_Start", 64'(eng_Start), 64'd0);
    check("reset eng_Ack", 64'(eng_Ack), 64'd0);
    check("reset eng_width", 64'(eng_width), 64'd0);
    checkWide("reset eng_Ain", eng_Ain, '0);
`ifdef SORT_STATS_EN
    check("reset jobs_done", 64'(jobs_done), 64'd0);
    check("reset busy_cycles", 64'(busy_cycles), 64'd0);
`endif
    phase = PH_FREE; mPtr = 0; mOwner = 0; mJobs = 0; mBusyCycles = 0;
    expAccept = '0; expRspValid = '0; expStart = 1'b0; expBusy = 1'b0; expAck = 1'b0;
    engRunning = 1'b0; engCount = 0; engDropCount = 0; eng_Done = 1'b0;
    req_valid = '0; rsp_ack = '0;
    for (int i = 0; i < N_REQ; i++) injPend[i] = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b0;
  endtask

  task automatic waitAccept(input string name, output logic [N_REQ-1:0] acc);
    acc = '0;
    for (int c = 0; c < 200; c++) begin
      stepCycle();
      if (req_accept != '0) begin
        acc = req_accept;
        return;
      end
    end
    timeoutFail(name);
  endtask

  task automatic waitRsp(input string name);
    for (int c = 0; c < 300; c++) begin
      stepCycle();
      if (rsp_valid != '0) return;
    end
    timeoutFail(name);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 4000; c++) begin
      if (req_valid == '0 && !busy && !anyInj()) return;
      stepCycle();
    end
    timeoutFail(name);
  endtask

  initial begin
    logic [N_REQ-1:0] acc;
    logic [ARR_W-1:0] arr, snap;
    int               exp1[5];

    Reset = 1'b1;
    req_valid = '0; req_width = '0; req_data = '0; rsp_ack = '0;
    eng_Done = 1'b0; eng_Aout = '0;
    holdAll = 1'b0; autoReq = 1'b0; ackBlock = 1'b0;
    engLatMin = 2; engLatMax = 6;
    applyReset();

    // Single job on client 0, width 5
    exp1 = '{1, 3, 4, 7, 9};
    arr = randArr();
    arr[0*ELEM_W +: ELEM_W] = 7'd9;
    arr[1*ELEM_W +: ELEM_W] = 7'd3;
    arr[2*ELEM_W +: ELEM_W] = 7'd7;
    arr[3*ELEM_W +: ELEM_W] = 7'd1;
    arr[4*ELEM_W +: ELEM_W] = 7'd4;
    queueJob(0, 5, arr);
    waitAccept("t1 accept wait", acc);
    check("t1 accept", 64'(acc), 64'b0001);
    waitRsp("t1 rsp wait");
    check("t1 rsp_valid", 64'(rsp_valid), 64'b0001);
    for (int i = 0; i < 5; i++) check("t1 sorted elem", 64'(rsp_data[i*ELEM_W +: ELEM_W]), 64'(exp1[i]));
    check("t1 untouched tail", 64'(rsp_data[ARR_W-1:5*ELEM_W] == arr[ARR_W-1:5*ELEM_W]), 64'd1);
    drain("t1 drain");

    // All four clients hold requests: grant order 0,1,2,3,0
    applyReset();
    grantLog.delete();
    holdAll = 1'b1;
    for (int i = 0; i < N_REQ; i++) queueJob(i, $urandom_range(31, 0), randArr());
    for (int c = 0; c < 3000 && grantLog.size() < 5; c++) stepCycle();
    if (grantLog.size() < 5) timeoutFail("t2 grants");
    else begin
      check("t2 grant0", 64'(grantLog[0]), 64'd0);
      check("t2 grant1", 64'(grantLog[1]), 64'd1);
      check("t2 grant2", 64'(grantLog[2]), 64'd2);
      check("t2 grant3", 64'(grantLog[3]), 64'd3);
      check("t2 grant4", 64'(grantLog[4]), 64'd0);
    end
    holdAll = 1'b0;
    drain("t2 drain");

    // Width clamp and trivial widths
    queueJob(2, 31, randArr());
    waitAccept("t3 accept wait", acc);
    check("t3 eng_width clamp", 64'(eng_width), 64'd30);
    waitRsp("t3 rsp wait");
    drain("t3 drain");
    arr = randArr();
    queueJob(1, 0, arr);
    waitRsp("t3 w0 rsp wait");
    checkWide("t3 w0 unchanged", rsp_data, arr);
    drain("t3 w0 drain");
    arr = randArr();
    queueJob(3, 1, arr);
    waitRsp("t3 w1 rsp wait");
    checkWide("t3 w1 unchanged", rsp_data, arr);
    drain("t3 w1 drain");

    // Stalled consumer, then a single eng_Ack pulse
    ackBlock = 1'b1;
    queueJob(1, 8, randArr());
    waitRsp("t4 rsp wait");
    snap = rsp_data;
    for (int c = 0; c < 50; c++) begin
      stepCycle();
      checkWide("t4 rsp_data stable", rsp_data, snap);
      check("t4 no eng_Ack", 64'(eng_Ack), 64'd0);
    end
    ackPulses = 0;
    ackBlock  = 1'b0;
    drain("t4 drain");
    check("t4 ack pulses", 64'(ackPulses), 64'd1);

    // Reset while the engine is running; client 0 wins afterwards
    engLatMin = 20; engLatMax = 30;
    queueJob(0, 12, randArr());
    drain("t5 first job");
    queueJob(1, 12, randArr());
    waitAccept("t5 accept wait", acc);
    for (int c = 0; c < 3; c++) stepCycle();
    check("t5 busy before reset", 64'(busy), 64'd1);
    applyReset();
    engLatMin = 1; engLatMax = 6;
    queueJob(0, 6, randArr());
    queueJob(1, 6, randArr());
    waitAccept("t5 post accept wait", acc);
    check("t5 post-reset winner", 64'(acc), 64'b0001);
    drain("t5 drain");

    // Random traffic with ack noise on non-owner bits
    autoReq = 1'b1;
    for (int c = 0; c < 2000; c++) stepCycle();
    autoReq = 1'b0;
    drain("random drain");

`ifdef SORT_STATS_EN
    // Three jobs from a clean reset
    applyReset();
    for (int j = 0; j < 3; j++) begin
      queueJob(j, $urandom_range(31, 0), randArr());
      drain("t6 job");
    end
    stepCycle();
    check("t6 jobs_done", 64'(jobs_done), 64'd3);
    check("t6 busy_cycles", 64'(busy_cycles), 64'(mBusyCycles));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
